// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 transmitter and the future receiver.
// Holds the line-phase state encoding, the frame length, the line levels for
// start, stop and idle, and the odd-parity and frame-building helpers.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } ps2_state_t;

    localparam int   PS2_FRAME_BITS  = 11;
    localparam logic PS2_START_LEVEL = 1'b0;
    localparam logic PS2_STOP_LEVEL  = 1'b1;
    localparam logic PS2_IDLE_LEVEL  = 1'b1;

    // Odd parity: the 8 data bits plus this bit always hold an odd number of ones.
    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Frame laid out with bit 0 sent first: start, data LSB..MSB, parity, stop.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_build_frame(input logic [7:0] data);
        return {PS2_STOP_LEVEL, ps2_odd_parity(data), data, PS2_START_LEVEL};
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// ps2_tx_fifo: synchronous byte FIFO for the PS/2 transmitter.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   push, push_data write request and byte (ignored while full)
//   pop, pop_data   read request and head byte (pop_data valid while !empty)
//   full, empty     occupancy flags
//   count           entries held (one bit wider than the pointers)
module ps2_tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 8,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // The count, not the pointers, tells full from empty since the pointers wrap.
    assign full      = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: device-side PS/2 transmitter.
// Bytes accepted on a valid/ready port are queued and sent as 11-bit frames
// (start, 8 data LSB first, odd parity, stop). Each bit spends CLK_DIV cycles
// with ps2_clk high (data set up) and CLK_DIV cycles low (data held); frames
// are separated by GAP_CYCLES idle cycles.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   in_valid, in_data   byte offered for transmission
//   in_ready            FIFO can accept (0 while full or in reset)
//   ps2_clk, ps2_data   registered PS/2 lines, idle high
//   busy                frame/gap in progress or bytes queued
//   fifo_count          bytes waiting in the FIFO
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 8,
    parameter int GAP_CYCLES = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          ps2_clk,
    output logic                          ps2_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int TMR_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int IDX_W   = $clog2(PS2_FRAME_BITS + 1);

    ps2_state_t                state_r;
    ps2_state_t                state_s;
    logic [TMR_W-1:0]          timer_r;
    logic [TMR_W-1:0]          timer_s;
    logic [IDX_W-1:0]          bit_idx_r;
    logic [IDX_W-1:0]          bit_idx_s;
    logic [PS2_FRAME_BITS-1:0] frame_r;
    logic [PS2_FRAME_BITS-1:0] frame_s;
    logic                      pop_s;
    logic [7:0]                pop_data_s;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;
    logic                      ps2_clk_r;
    logic                      ps2_data_r;

    ps2_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid && in_ready),
        .push_data (in_data),
        .pop       (pop_s),
        .pop_data  (pop_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count)
    );

    assign in_ready = !fifo_full_s && !rst;
    assign busy     = (state_r != ST_IDLE) || (fifo_count != '0);
    assign ps2_clk  = ps2_clk_r;
    assign ps2_data = ps2_data_r;

    // FSM, half-period timer, bit index and frame shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            timer_r   <= {TMR_W{1'b0}};
            bit_idx_r <= {IDX_W{1'b0}};
            frame_r   <= {PS2_FRAME_BITS{PS2_IDLE_LEVEL}};
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_idx_r <= bit_idx_s;
            frame_r   <= frame_s;
        end
    end

    // Next-state logic: pop in IDLE, then alternate HIGH/LOW per bit, then GAP.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        bit_idx_s = bit_idx_r;
        frame_s   = frame_r;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    frame_s   = ps2_build_frame(pop_data_s);
                    bit_idx_s = {IDX_W{1'b0}};
                    timer_s   = {TMR_W{1'b0}};
                    state_s   = ST_HIGH;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (timer_r == TMR_W'(CLK_DIV - 1)) begin
                    timer_s = {TMR_W{1'b0}};
                    state_s = ST_LOW;
                end else begin
                    timer_s = timer_r + TMR_W'(1);
                end
            end
            ST_LOW: begin
                if (timer_r == TMR_W'(CLK_DIV - 1)) begin
                    timer_s = {TMR_W{1'b0}};
                    if (bit_idx_r == IDX_W'(PS2_FRAME_BITS - 1)) begin
                        state_s = ST_GAP;
                    end else begin
                        // Index moves only on LOW->HIGH, so data never changes while ps2_clk is low.
                        bit_idx_s = bit_idx_r + IDX_W'(1);
                        state_s   = ST_HIGH;
                    end
                end else begin
                    timer_s = timer_r + TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (timer_r == TMR_W'(GAP_CYCLES - 1)) begin
                    timer_s = {TMR_W{1'b0}};
                    state_s = ST_IDLE;
                end else begin
                    timer_s = timer_r + TMR_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Line registers follow the current state, so lines lag the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_clk_r  <= PS2_IDLE_LEVEL;
            ps2_data_r <= PS2_IDLE_LEVEL;
        end else begin
            case (state_r)
                ST_HIGH: begin
                    ps2_clk_r  <= 1'b1;
                    ps2_data_r <= frame_r[bit_idx_r];
                end
                ST_LOW: begin
                    ps2_clk_r  <= 1'b0;
                    ps2_data_r <= frame_r[bit_idx_r];
                end
                default: begin
                    ps2_clk_r  <= PS2_IDLE_LEVEL;
                    ps2_data_r <= PS2_IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: doc/ps2_tx.md
# ps2_tx

Device-side PS/2 transmitter: accepts scancode bytes over a valid/ready port, buffers them in a small FIFO and serialises each as an 11-bit PS/2 frame on `ps2_clk`/`ps2_data`. It is the sending end of the board's PS/2 input path. It serves as the keyboard model in simulation and as a loopback source feeding the PS/2 receiver in `top`.

## Interface
- `CLK_DIV`, 8: system clocks per PS/2 clock half-period (≥2).
- `GAP_CYCLES`, 16: idle cycles (clk/data high) after each frame's stop bit (≥1).
- `FIFO_DEPTH`, 8: byte FIFO entries, power of two.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` holds a byte to send.
- `in_data`  in  8  scancode byte.
- `in_ready`  out  1  FIFO can accept; transfer when `in_valid && in_ready`.
- `ps2_clk`  out  1  PS/2 clock, registered, idles 1.
- `ps2_data`  out  1  PS/2 data, registered, idles 1.
- `busy`  out  1  FIFO non-empty or frame/gap in progress.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries held.

## Operation
- Frame, in order: start 0, data[0]..data[7] (LSB first), odd parity (`~^data`), stop 1.
- FSM states:
  - IDLE: if FIFO non-empty, pop into a shift register, bit index=0, go to HIGH; else stay.
  - HIGH: `ps2_clk`=1 and `ps2_data`=current bit for CLK_DIV cycles, then go to LOW.
  - LOW: `ps2_clk`=0 and `ps2_data` held for CLK_DIV cycles. Then, if index=10, go to GAP; else index+1 and go to HIGH.
  - GAP: both lines 1 for GAP_CYCLES cycles, then go to IDLE.
- Data changes only on the first cycle of HIGH. It is never changed while `ps2_clk`=0.
- FIFO:
  - `in_ready = !full && !rst`.
  - Push and pop in the same cycle are legal. Count is unchanged.
  - When full, `in_ready`=0, so the push cannot happen. A pop that cycle frees a slot that is visible next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Count distinguishes full from empty.
- `busy = (state != IDLE) || (fifo_count != 0)`.
- Reset values: state IDLE, `ps2_clk`=1, `ps2_data`=1, FIFO empty, `fifo_count`=0, `in_ready`=0 during the reset cycle and 1 after, `busy`=0.
- Reset mid-frame:
  - Aborts the frame and flushes the FIFO.
  - Lines are high on the cycle after `rst` is sampled.
  - A truncated frame is acceptable; the host times it out.

## Timing
- Byte accepted at cycle t into an idle, empty block:
  - Pop at t+1.
  - Start bit visible on `ps2_data` at t+2 with `ps2_clk`=1.
  - First falling edge of `ps2_clk` at t+2+CLK_DIV.
- Each bit is 2·CLK_DIV cycles. Data is set up CLK_DIV cycles before the falling edge and held CLK_DIV cycles after it.
- Frame (start through end of stop LOW) is 22·CLK_DIV cycles.
- Back-to-back frames start every 22·CLK_DIV + GAP_CYCLES + 1 cycles (the +1 is the IDLE pop cycle).
- `fifo_count` updates the cycle after a push or pop.

## Structure
- Shared package `ps2_pkg`:
  - state encoding (IDLE/HIGH/LOW/GAP);
  - `PS2_FRAME_BITS`=11;
  - start, stop and idle levels;
  - parity function (odd).
  - The future PS/2 receiver uses the same package.
- Sub-module `ps2_tx_fifo`: synchronous FIFO with `FIFO_DEPTH`, push/pop, full/empty/count. It is instantiated once.
- FSM, bit counter, half-period counter and shift register stay in `ps2_tx`.

## Test plan
- **Reset idle:** hold `rst` 3 cycles, release. Required: `ps2_clk`=`ps2_data`=1, `busy`=0, `in_ready`=1, `fifo_count`=0.
- **Single byte, CLK_DIV=8:** send 0x1C at cycle t. Required:
  - start bit at t+2, first falling edge at t+10;
  - sampling `ps2_data` on 11 falling edges gives 0,0,0,1,1,1,0,0,0,0(parity),1;
  - `busy` drops after 176+16 cycles.
- **Parity sweep:** send 0x00, 0xFF, 0x01, 0xF0. Required: parity bits 1, 1, 0, 1.
- **Back-to-back:** push 0x1C, 0xF0, 0x1C on consecutive cycles. Required: three frames decoded in order, start bits spaced exactly 22·8+16+1=193 cycles apart.
- **FIFO full:** hold `in_valid` with FIFO_DEPTH+2 distinct bytes. Required:
  - `in_ready` drops when `fifo_count`=8 (first byte already popped, so 9 accepted);
  - `in_ready` reasserts one cycle after the next pop;
  - all accepted bytes transmitted in order, none duplicated or lost.
- **Reset mid-frame:** assert `rst` during data bit 4 with 3 bytes queued. Required: lines high next cycle, `fifo_count`=0, `busy`=0, no further falling edges on `ps2_clk`.
